// File: rtl/asym_mult_pkg.sv
// Shared types and constants for the iterative asymmetric split multiplier.
package asym_mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // One sub-product is issued per CALC step, in this order.
    typedef logic [1:0] step_t;
    localparam step_t STEP_HH = 2'd0;
    localparam step_t STEP_HL = 2'd1;
    localparam step_t STEP_LH = 2'd2;
    localparam step_t STEP_LL = 2'd3;

    // Width of the high operand part; it also sets the shared sub-multiplier size.
    function automatic int hi_w(input int width, input int lo_w);
        return width - lo_w;
    endfunction

endpackage

// File: rtl/asym_sub_mult.sv
// Combinational exact unsigned HI_W x HI_W multiplier, shared by all four sub-products.
module asym_sub_mult #(
    parameter int HI_W = 17
) (
    input  logic [HI_W-1:0]   op_a_i,
    input  logic [HI_W-1:0]   op_b_i,
    output logic [2*HI_W-1:0] prod_o
);

    assign prod_o = (2*HI_W)'(op_a_i) * (2*HI_W)'(op_b_i);

endmodule

// File: rtl/asym_mult_iter.sv
// Iterative asymmetric split multiplier: four sub-products on one shared
// HI_W x HI_W multiplier, shift-accumulated, with an approximate mode that
// skips the low x low term.
module asym_mult_iter
    import asym_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LO_W  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_approx,
    output logic               busy
);

    localparam int HI_W = hi_w(WIDTH, LO_W);
    localparam int PW   = 2 * WIDTH;

    state_t            state_q, state_d;
    step_t             step_q, step_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              approx_q, approx_d;
    logic [PW-1:0]     out_p_q, out_p_d;
    logic              out_valid_q, out_valid_d;
    logic              out_approx_q, out_approx_d;

    logic [HI_W-1:0]   a_hi, b_hi;
    logic [LO_W-1:0]   a_lo, b_lo;
    logic [HI_W-1:0]   op_a, op_b;
    logic [2*HI_W-1:0] prod;
    logic [PW-1:0]     prod_ext, term, acc_sum;
    logic              last_step;

    assign a_hi = a_q[WIDTH-1:LO_W];
    assign a_lo = a_q[LO_W-1:0];
    assign b_hi = b_q[WIDTH-1:LO_W];
    assign b_lo = b_q[LO_W-1:0];

    // Route the operand parts for the current step into the shared multiplier;
    // low parts are zero-extended up to HI_W.
    always_comb begin
        op_a = a_hi;
        op_b = b_hi;
        case (step_q)
            STEP_HH: begin op_a = a_hi;         op_b = b_hi;         end
            STEP_HL: begin op_a = b_hi;         op_b = HI_W'(a_lo);  end
            STEP_LH: begin op_a = a_hi;         op_b = HI_W'(b_lo);  end
            default: begin op_a = HI_W'(a_lo); op_b = HI_W'(b_lo);  end
        endcase
    end

    asym_sub_mult #(.HI_W(HI_W)) u_sub_mult (
        .op_a_i (op_a),
        .op_b_i (op_b),
        .prod_o (prod)
    );

    assign prod_ext = PW'(prod);

    // Align the sub-product to its weight: HH sits at 2*LO_W, the cross terms at LO_W.
    always_comb begin
        term = prod_ext;
        case (step_q)
            STEP_HH:          term = prod_ext << (2 * LO_W);
            STEP_HL, STEP_LH: term = prod_ext << LO_W;
            default:          term = prod_ext;
        endcase
    end

    assign acc_sum   = acc_q + term;
    // Approx mode stops before the low x low term.
    assign last_step = approx_q ? (step_q == STEP_LH) : (step_q == STEP_LL);

    // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        acc_d        = acc_q;
        a_d          = a_q;
        b_d          = b_q;
        approx_d     = approx_q;
        out_p_d      = out_p_q;
        out_valid_d  = out_valid_q;
        out_approx_d = out_approx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    approx_d = in_approx;
                    acc_d    = '0;
                    step_d   = STEP_HH;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (last_step) begin
                    out_p_d      = acc_sum;
                    out_valid_d  = 1'b1;
                    out_approx_d = approx_q;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            step_q       <= STEP_HH;
            acc_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            approx_q     <= 1'b0;
            out_p_q      <= '0;
            out_valid_q  <= 1'b0;
            out_approx_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            approx_q     <= approx_d;
            out_p_q      <= out_p_d;
            out_valid_q  <= out_valid_d;
            out_approx_q <= out_approx_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign out_p      = out_p_q;
    assign out_approx = out_approx_q;

endmodule

// File: tb/tb_asym_mult_iter.sv
// Directed bench for asym_mult_iter: a 5-bit instance for protocol, reset and
// exhaustive checks, and a 32-bit instance for wide-operand corner values.
module tb_asym_mult_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 5-bit instance, LO_W=2
    logic       iv5, ir5, ap5, ov5, or5, oap5, busy5;
    logic [4:0] a5, b5;
    logic [9:0] p5;

    asym_mult_iter #(.WIDTH(5), .LO_W(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5),
        .in_a(a5), .in_b(b5), .in_approx(ap5), .out_valid(ov5),
        .out_ready(or5), .out_p(p5), .out_approx(oap5), .busy(busy5)
    );

    // 32-bit instance, LO_W=15
    logic        iv32, ir32, ap32, ov32, or32, oap32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] p32;

    asym_mult_iter #(.WIDTH(32), .LO_W(15)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .in_a(a32), .in_b(b32), .in_approx(ap32), .out_valid(ov32),
        .out_ready(or32), .out_p(p32), .out_approx(oap32), .busy(busy32)
    );

    // Drive one operation into dut5 and return the result and the number of
    // edges from accept to out_valid (20 means it never arrived).
    task automatic op5(input logic [4:0] a, input logic [4:0] b, input logic apx,
                       output logic [9:0] p, output logic pm, output int lat);
        int w = 0;
        while (!ir5 && w < 20) begin @(posedge clk); #1; w++; end
        iv5 = 1'b1; a5 = a; b5 = b; ap5 = apx;
        @(posedge clk); #1;
        // Scramble inputs after accept: they must not affect the result.
        iv5 = 1'b0; a5 = ~a; b5 = ~b; ap5 = ~apx;
        lat = 0;
        while (!ov5 && lat < 20) begin @(posedge clk); #1; lat++; end
        p = p5; pm = oap5;
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic apx,
                        output logic [63:0] p, output logic pm, output int lat);
        int w = 0;
        while (!ir32 && w < 20) begin @(posedge clk); #1; w++; end
        iv32 = 1'b1; a32 = a; b32 = b; ap32 = apx;
        @(posedge clk); #1;
        iv32 = 1'b0; a32 = ~a; b32 = ~b; ap32 = ~apx;
        lat = 0;
        while (!ov32 && lat < 20) begin @(posedge clk); #1; lat++; end
        p = p32; pm = oap32;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (ov5 !== 1'b0 || p5 !== 10'd0 || oap5 !== 1'b0 || busy5 !== 1'b0) begin
            failures++; $display("FAIL reset_outs5 ov=%b p=%0d oap=%b busy=%b want 0 0 0 0", ov5, p5, oap5, busy5); end
        checks++; if (ov32 !== 1'b0 || p32 !== 64'd0 || busy32 !== 1'b0) begin
            failures++; $display("FAIL reset_outs32 ov=%b p=%0h busy=%b want 0 0 0", ov32, p32, busy32); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ir5 !== 1'b1 || ir32 !== 1'b1) begin
            failures++; $display("FAIL reset_ready ir5=%b ir32=%b want 1 1", ir5, ir32); end
    endtask

    task automatic test_exact5();
        logic [9:0] p; logic pm; int lat;
        op5(5'd31, 5'd31, 1'b0, p, pm, lat);
        checks++; if (p !== 10'd961) begin failures++; $display("FAIL exact5_p got %0d want 961", p); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL exact5_lat got %0d want 4", lat); end
        checks++; if (pm !== 1'b0) begin failures++; $display("FAIL exact5_mode got %b want 0", pm); end
        @(posedge clk); #1;
        checks++; if (ir5 !== 1'b1 || ov5 !== 1'b0) begin
            failures++; $display("FAIL exact5_ret ir=%b ov=%b want 1 0", ir5, ov5); end
    endtask

    task automatic test_approx5();
        logic [9:0] p; logic pm; int lat;
        op5(5'd31, 5'd31, 1'b1, p, pm, lat);
        checks++; if (p !== 10'd952) begin failures++; $display("FAIL approx5_p got %0d want 952", p); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL approx5_lat got %0d want 3", lat); end
        checks++; if (pm !== 1'b1) begin failures++; $display("FAIL approx5_mode got %b want 1", pm); end
        op5(5'd1, 5'd1, 1'b1, p, pm, lat);
        checks++; if (p !== 10'd0) begin failures++; $display("FAIL approx5_1x1 got %0d want 0", p); end
        op5(5'd5, 5'd6, 1'b1, p, pm, lat);
        checks++; if (p !== 10'd28) begin failures++; $display("FAIL approx5_5x6 got %0d want 28", p); end
    endtask

    task automatic test_wide32();
        logic [63:0] p; logic pm; int lat;
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, pm, lat);
        checks++; if (p !== 64'hFFFF_FFFE_0000_0001 || lat !== 4) begin
            failures++; $display("FAIL w32_max p=%0h lat=%0d want fffffffe00000001 4", p, lat); end
        op32(32'h0, 32'hFFFF_FFFF, 1'b0, p, pm, lat);
        checks++; if (p !== 64'h0) begin failures++; $display("FAIL w32_zero got %0h want 0", p); end
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, p, pm, lat);
        checks++; if (p !== 64'hFFFF_FFFD_C001_0000 || lat !== 3 || pm !== 1'b1) begin
            failures++; $display("FAIL w32_approx p=%0h lat=%0d m=%b want fffffffdc0010000 3 1", p, lat, pm); end
        op32(32'h8000, 32'h8000, 1'b1, p, pm, lat);
        checks++; if (p !== 64'h4000_0000) begin failures++; $display("FAIL w32_split got %0h want 40000000", p); end
        op32(32'd3, 32'd5, 1'b1, p, pm, lat);
        checks++; if (p !== 64'h0) begin failures++; $display("FAIL w32_lowonly got %0h want 0", p); end
    endtask

    task automatic test_backpressure();
        logic [9:0] p; logic pm; int lat;
        or5 = 1'b0;
        op5(5'd13, 5'd11, 1'b0, p, pm, lat);
        checks++; if (p !== 10'd143 || lat !== 4) begin
            failures++; $display("FAIL bp_first p=%0d lat=%0d want 143 4", p, lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin iv5 = 1'b1; a5 = 5'd1; b5 = 5'd1; ap5 = 1'b0; end
            checks++; if (ov5 !== 1'b1 || p5 !== 10'd143 || ir5 !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d ov=%b p=%0d ir=%b want 1 143 0", i, ov5, p5, ir5); end
        end
        iv5 = 1'b0;
        or5 = 1'b1;
        @(posedge clk); #1;
        checks++; if (ov5 !== 1'b0 || ir5 !== 1'b1 || p5 !== 10'd143) begin
            failures++; $display("FAIL bp_release ov=%b ir=%b p=%0d want 0 1 143", ov5, ir5, p5); end
        op5(5'd2, 5'd3, 1'b0, p, pm, lat);
        checks++; if (p !== 10'd6) begin failures++; $display("FAIL bp_next got %0d want 6", p); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] p; logic pm; int lat;
        int w = 0;
        while (!ir5 && w < 20) begin @(posedge clk); #1; w++; end
        iv5 = 1'b1; a5 = 5'd31; b5 = 5'd31; ap5 = 1'b0;
        @(posedge clk); #1;
        iv5 = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy5 !== 1'b1) begin failures++; $display("FAIL rmid_busy got %b want 1", busy5); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ov5 !== 1'b0 || p5 !== 10'd0 || busy5 !== 1'b0 || ir5 !== 1'b1) begin
            failures++; $display("FAIL rmid_clear ov=%b p=%0d busy=%b ir=%b want 0 0 0 1", ov5, p5, busy5, ir5); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        op5(5'd6, 5'd7, 1'b0, p, pm, lat);
        checks++; if (p !== 10'd42 || lat !== 4) begin
            failures++; $display("FAIL rmid_after p=%0d lat=%0d want 42 4", p, lat); end
    endtask

    task automatic test_exhaustive5();
        logic [9:0] p, exp; logic pm; int lat;
        int bad = 0;
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 32; a++) begin
                for (int b = 0; b < 32; b++) begin
                    exp = 10'(a * b);
                    if (m == 1) exp = 10'(a * b - (a % 4) * (b % 4));
                    op5(5'(a), 5'(b), 1'(m), p, pm, lat);
                    checks++;
                    if (p !== exp || pm !== 1'(m) || lat !== (m == 1 ? 3 : 4)) begin
                        failures++;
                        if (bad < 10) $display("FAIL exh a=%0d b=%0d m=%0d p=%0d lat=%0d want %0d %0d",
                                               a, b, m, p, lat, exp, (m == 1 ? 3 : 4));
                        bad++;
                    end
                end
            end
        end
    endtask

    initial begin
        iv5 = 1'b0; a5 = '0; b5 = '0; ap5 = 1'b0; or5 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; ap32 = 1'b0; or32 = 1'b1;
        test_reset();
        test_exact5();
        test_approx5();
        test_wide32();
        test_backpressure();
        test_reset_mid();
        test_exhaustive5();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
